// File: rtl/serial_pkg.sv
// serial_pkg -- definitions shared by the serial blocks (uart_rx and the
// matching uart_tx).
//
// Contents:
//   DEF_CLKS_PER_BIT : default clock cycles per serial bit (16)
//   DEF_DATA_BITS    : default data bits per frame (8)
//   serial_state_e   : frame FSM state encodings
//
// Configuration macro: UART_RX_PARITY_EN
//   defined   -> the state set includes ST_PARITY (even-parity bit after data)
//   undefined -> start + data + stop only, no ST_PARITY encoding exists
package serial_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } serial_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } serial_state_e;
`endif

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous input.
//
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both stages reset to 1 so an
//           idle-high serial line does not see a spurious falling edge
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver with a valid/ready output handshake.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (even, >= 4)
//   DATA_BITS    : data bits per frame (5..8), sent LSB first
//
// Ports:
//   clk        : system clock, all state updates on its rising edge
//   rst_n      : asynchronous active-low reset
//   rxd        : asynchronous serial line, idles high
//   rx_data    : received word, stable while rx_valid is high
//   rx_valid   : rx_data holds an unconsumed word
//   rx_ready   : consumer accepts; transfer on rx_valid && rx_ready
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   overrun    : one-cycle pulse when a completed word is dropped
//   parity_err : (UART_RX_PARITY_EN only) one-cycle pulse on parity mismatch
//
// Configuration macro: UART_RX_PARITY_EN
//   defined   -> an even-parity bit is expected between data and stop
//   undefined -> frame is start + data + stop, no parity_err port
//
// A frame is only accepted after a high level has been seen on the
// synchronized line since the previous frame (or since reset), so a line
// stuck low after a framing error or reset never starts a new frame.
module uart_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  // Sample points: half a bit into the start bit, then one full bit later
  // for every following bit, so each sample lands mid-bit.
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic rxd_s;

  serial_state_e        state_q,    state_d;
  logic [CNT_W-1:0]     samp_cnt_q, samp_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 armed_q,    armed_d;
  logic [1:0]           sync_vld_q, sync_vld_d;
  logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,  overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q,    par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    // The synchronizer stages come out of reset holding 1, which is not a
    // real observation of the line. sync_vld_q[1] marks the point where
    // rxd_s reflects rxd sampled after reset release.
    sync_vld_d = {sync_vld_q[0], 1'b1};

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        samp_cnt_d = '0;
        bit_cnt_d  = '0;
        if (sync_vld_q[1]) begin
          if (rxd_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        if (samp_cnt_q == HALF_M1) begin
          samp_cnt_d = '0;
          state_d    = rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          samp_cnt_d = samp_cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (samp_cnt_q == FULL_M1) begin
          samp_cnt_d = '0;
          shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          samp_cnt_d = samp_cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (samp_cnt_q == FULL_M1) begin
          samp_cnt_d = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d  = ^{shift_q, rxd_s};
          state_d    = ST_STOP;
        end else begin
          samp_cnt_d = samp_cnt_q + CNT_W'(1);
        end
      end
`endif

      ST_STOP: begin
        if (samp_cnt_q == FULL_M1) begin
          samp_cnt_d = '0;
          state_d    = ST_IDLE;
          armed_d    = 1'b0;
          if (!rxd_s) begin
            frame_err_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad_q) begin
            parity_err_d = 1'b1;
          end
`endif
          // Either the holding register is free or it is being emptied in
          // this very cycle; in both cases the new word takes its place.
          else if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          samp_cnt_d = samp_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        samp_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      sync_vld_q  <= 2'b00;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      sync_vld_q  <= sync_vld_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, is clock cycles per serial bit; it SHALL be even and at least 4.
REQ-002 Parameter DATA_BITS, default 8, is data bits per frame; it SHALL be in the range 5..8.
REQ-003 clk  input  1  system clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rxd  input  1  asynchronous serial line; idles high.
REQ-006 rx_data  output  DATA_BITS  received byte, held stable while rx_valid is high.
REQ-007 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 rx_ready  input  1  consumer accepts; a transfer occurs on a cycle with rx_valid && rx_ready.
REQ-009 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 rxd SHALL pass through a 2-stage synchronizer before any use; all sampling below refers to the synchronized signal.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, plus PARITY when the parity feature is enabled.
REQ-013 IDLE SHALL move to START on a falling edge (1->0) of the synchronized rxd, and only if a high level was seen after the last frame.
REQ-014 START SHALL re-sample the line CLKS_PER_BIT/2 cycles after the edge: low -> DATA; high -> IDLE (false start, no outputs).
REQ-015 DATA SHALL sample every CLKS_PER_BIT cycles, LSB first, for DATA_BITS samples, then go to STOP (or PARITY).
REQ-016 STOP SHALL sample once, then return to IDLE in the next cycle.
REQ-017 A stop sample of 1 SHALL complete the frame; a stop sample of 0 SHALL pulse frame_err and discard the byte.
REQ-018 On completion with rx_valid low, rx_data SHALL load and rx_valid SHALL rise on the next cycle.
REQ-019 rx_valid SHALL stay high, with rx_data unchanged, until a transfer occurs.
REQ-020 On completion with rx_valid high and rx_ready low, the new byte SHALL be dropped, the old byte kept, and overrun pulsed.
REQ-021 On completion in the same cycle as a transfer, the new byte SHALL load, rx_valid SHALL stay high, and overrun SHALL NOT pulse.
REQ-022 Latency: rx_valid SHALL rise 154-156 clk cycles after the rxd falling edge (CLKS_PER_BIT=16, DATA_BITS=8, parity off).
REQ-023 The bit counter and sample counter SHALL be sized by $clog2 of their limits and SHALL never wrap within a frame.

Reset
REQ-024 While rst_n is low: FSM = IDLE, counters = 0, rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, synchronizer stages = 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no output pulses.
REQ-026 After rst_n release, a start SHALL require rxd to be seen high first.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: a PARITY state samples an even-parity bit after the data bits.
REQ-028 With UART_RX_PARITY_EN, a mismatch SHALL pulse output parity_err for one cycle on completion and discard the byte; parity_err SHALL be reset to 0.
REQ-029 Macro UART_RX_PARITY_EN undefined: there SHALL be no PARITY state and no parity_err port; the frame is start + data + stop.

Structure
REQ-030 FSM state encodings and default CLKS_PER_BIT/DATA_BITS constants SHALL live in shared package serial_pkg, for reuse by the matching uart_tx.
REQ-031 The synchronizer SHALL be sub-module sync_2ff (clk, rst_n, d, q), built from two reset-to-1 flops.

Verification
REQ-032 Send 0xA5 at 16 clks/bit, rx_ready=1 -> rx_data=0xA5, rx_valid high for 1 cycle, rising 154-156 cycles after the start edge.
REQ-033 rxd low for 6 cycles then high -> no state past START, rx_valid=0, no pulses.
REQ-034 Send 0x3C with stop bit 0 -> frame_err pulses once, rx_valid stays 0; next frame 0x11 is received only after rxd returns high.
REQ-035 Send 0x01 then 0x02 with rx_ready=0 -> rx_data=0x01 is held, overrun pulses once at the 0x02 stop sample.
REQ-036 Assert rx_ready in the exact cycle 0x02 completes -> 0x01 transfers, rx_data=0x02, rx_valid stays high, overrun=0.
REQ-037 Pull rst_n low during data bit 4 -> all outputs 0 immediately; the next full frame 0x7E is received correctly.
